// File: rtl/led_rate_sched.sv
// led_rate_sched: switch-selected tick scheduler driving an LED pattern.
// Owns the select of an external 4-way constant-limit mux. The select comes
// from synchronized, debounced switches. The returned limit is latched and
// used as a tick period. Each tick advances the LED pattern.
// Optional build macro: LED_BOUNCE_EN selects a ping-pong LED walk instead of
// the plain left rotation.
module led_rate_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NB_SW      = 2,
  parameter int NB_LEDS    = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [NB_SW-1:0]      i_sw,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_limit,
  output logic [NB_SW-1:0]      o_sel,
  output logic                  o_tick,
  output logic [NB_LEDS-1:0]    o_led,
  output logic                  o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // The stability counter saturates at DEB_CYCLES. It is loaded with 1 on a
  // candidate reload, because the reload cycle is the first cycle in which the
  // candidate holds its new value.
  localparam int                DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [NB_SW-1:0]      r_sw_s1;
  logic [NB_SW-1:0]      r_sw_s2;
  logic [NB_SW-1:0]      r_cand;
  logic [DEB_W-1:0]      r_stab;
  logic [NB_SW-1:0]      r_deb;

  logic [1:0]            r_state;
  logic [NB_SW-1:0]      r_sel;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_limit;
  logic                  r_tick;
  logic                  r_busy;
  logic [NB_LEDS-1:0]    r_led;

  logic [DATA_WIDTH-1:0] w_eff;
  logic                  w_wrap;
  logic                  w_led_adv;
  logic [NB_LEDS-1:0]    w_led_nxt;

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= i_sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Debounce: accept the candidate once it has held for DEB_CYCLES cycles.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_cand <= '0;
      r_stab <= '0;
      r_deb  <= '0;
    end else if (r_sw_s2 != r_cand) begin
      r_cand <= r_sw_s2;
      r_stab <= DEB_W'(1);
    end else begin
      if (r_stab >= DEB_LAST) r_deb <= r_cand;
      if (r_stab < DEB_MAX)   r_stab <= r_stab + DEB_W'(1);
    end
  end

  // A latched limit of zero behaves as one, so RUN ticks every cycle.
  assign w_eff  = (r_limit == '0) ? DATA_WIDTH'(1) : r_limit;
  assign w_wrap = (r_cnt == w_eff - DATA_WIDTH'(1));

  // A wrap only counts when neither the disable nor the reselect path wins.
  assign w_led_adv = (r_state == ST_RUN) && i_enable && (r_deb == r_sel) && w_wrap;

  // Schedule FSM: IDLE -> LOAD (one settle cycle for the mux) -> RUN.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_limit <= '0;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt  <= '0;
          r_busy <= 1'b0;
          if (i_enable) begin
            r_sel   <= r_deb;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_limit <= i_limit;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!i_enable) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_deb != r_sel) begin
            r_sel   <= r_deb;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_LOAD;
          end else if (w_led_adv) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
          end else begin
            r_cnt <= r_cnt + DATA_WIDTH'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LED_BOUNCE_EN
  logic r_dir;  // 0 = walking toward MSB, 1 = walking toward LSB

  assign w_led_nxt = r_dir ? (r_led >> 1) : (r_led << 1);

  // Ping-pong LED walk; direction flips when the lit bit reaches either end.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_led <= NB_LEDS'(1);
      r_dir <= 1'b0;
    end else if (w_led_adv) begin
      r_led <= w_led_nxt;
      if (w_led_nxt[NB_LEDS-1])  r_dir <= 1'b1;
      else if (w_led_nxt[0])     r_dir <= 1'b0;
    end
  end
`else
  assign w_led_nxt = {r_led[NB_LEDS-2:0], r_led[NB_LEDS-1]};

  // Rotate the LED pattern left by one on every tick.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset)        r_led <= NB_LEDS'(1);
    else if (w_led_adv) r_led <= w_led_nxt;
  end
`endif

  assign o_sel  = r_sel;
  assign o_tick = r_tick;
  assign o_led  = r_led;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_led_rate_sched.sv
// Directed bench for led_rate_sched with a scoreboard of expected ticks.
// Expected LED values and tick intervals are pushed as stimulus is applied and
// popped by a negedge monitor whenever the DUT pulses o_tick.
module tb_led_rate_sched;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_sw;
  logic        i_enable;
  logic [31:0] i_limit;
  logic [1:0]  o_sel;
  logic        o_tick;
  logic [3:0]  o_led;
  logic        o_busy;

  logic [31:0] lim [4];
  assign i_limit = lim[o_sel];

  led_rate_sched #(.DATA_WIDTH(32), .NB_SW(2), .NB_LEDS(4), .DEB_CYCLES(16)) dut (
    .clk(clk), .i_reset(i_reset), .i_sw(i_sw), .i_enable(i_enable),
    .i_limit(i_limit), .o_sel(o_sel), .o_tick(o_tick), .o_led(o_led), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         period;  // cycles since previous tick; 0 = not checked
    logic [3:0] led;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   last_tick = 0;

  logic [3:0] m_led;
  logic       m_dir;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference LED pattern and queue one expected tick.
  task automatic push_tick(input int period);
    logic [3:0] nxt;
    exp_t e;
`ifdef LED_BOUNCE_EN
    nxt = m_dir ? (m_led >> 1) : (m_led << 1);
    if (nxt == 4'b1000)      m_dir = 1'b1;
    else if (nxt == 4'b0001) m_dir = 1'b0;
`else
    nxt = {m_led[2:0], m_led[3]};
`endif
    m_led = nxt;
    e.period = period;
    e.led    = nxt;
    sb.push_back(e);
  endtask

  // Count rising edges until o_tick is seen at a falling edge (bounded).
  task automatic wait_tick(input int exp_n, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (o_tick !== 1'b1 && n < 64);
    chk(n, exp_n, tag);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // Tick monitor: every tick must be expected, in RUN, with the right LED and spacing.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (o_tick === 1'b1) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL tick_unexpected: got tick at cycle %0d expected none", cyc);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk(o_led, e.led, "tick_led");
        chk(o_busy, 1'b1, "tick_in_run");
        if (e.period != 0) chk(cyc - last_tick, e.period, "tick_period");
      end
      last_tick = cyc;
    end
  end

  initial begin
    int n;
    lim[0] = 3; lim[1] = 10; lim[2] = 5; lim[3] = 7;
    m_led = 4'b0001; m_dir = 1'b0;
    i_reset = 1'b1; i_sw = 2'b00; i_enable = 1'b0;
    cycles(2);

    // Reset values
    chk(o_sel, 2'b00, "rst_sel");
    chk(o_led, 4'b0001, "rst_led");
    chk(o_tick, 1'b0, "rst_tick");
    chk(o_busy, 1'b0, "rst_busy");

    // Start at select 0 (limit 3): IDLE -> LOAD -> RUN
    i_reset = 1'b0; i_enable = 1'b1;
    cycles(1);
    chk(o_busy, 1'b0, "load_busy");
    chk(o_sel, 2'b00, "load_sel");
    cycles(1);
    chk(o_busy, 1'b1, "run_busy");
    push_tick(0); push_tick(3); push_tick(3); push_tick(3);
    wait_tick(3, "first_tick_lat");
    wait_tick(3, "p3_a");
    wait_tick(3, "p3_b");
    wait_tick(3, "p3_c");
    chk(o_led, 4'b0001, "led_wrap");

    // 5-cycle glitch to 01 must be rejected; period stays 3
    for (int i = 0; i < 10; i++) push_tick(3);
    fork
      begin
        i_sw = 2'b01;
        repeat (5) @(posedge clk);
        i_sw = 2'b00;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          wait_tick(3, "glitch_p3");
          chk(o_sel, 2'b00, "glitch_sel");
        end
      end
    join
    cycles(0);

    // Stable switch to 01: 2 sync + 16 stable + 1 registering edge
    for (int i = 0; i < 6; i++) push_tick(3);
    i_sw = 2'b01;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (o_sel !== 2'b01 && n < 40);
    chk(n, 19, "deb_latency");
    chk(o_busy, 1'b0, "reselect_load");
    push_tick(0); push_tick(10); push_tick(10);
    wait_tick(11, "p10_first");
    wait_tick(10, "p10_a");
    wait_tick(10, "p10_b");

    // Drop enable at count 1: IDLE next cycle, no tick, LED holds
    cycles(1);
    i_enable = 1'b0;
    cycles(1);
    chk(o_busy, 1'b0, "dis_busy");
    chk(o_tick, 1'b0, "dis_tick");
    chk(o_led, m_led, "dis_led");
    cycles(3);
    chk(o_led, m_led, "idle_led_hold");
    i_enable = 1'b1;
    push_tick(0);
    wait_tick(12, "reenable_full_period");

    // Limit 0 on select 1: tick every RUN cycle
    i_enable = 1'b0;
    cycles(1);
    lim[1] = 0;
    i_enable = 1'b1;
    push_tick(0);
    for (int i = 0; i < 5; i++) push_tick(1);
    wait_tick(3, "lim0_first");
    for (int i = 0; i < 5; i++) wait_tick(1, "lim0_every");

    // Asynchronous reset mid-RUN at count 2
    i_enable = 1'b0;
    cycles(1);
    lim[1] = 3;
    i_enable = 1'b1;
    cycles(4);
    chk(o_busy, 1'b1, "pre_rst_busy");
    i_reset = 1'b1;
    #1;
    chk(o_sel, 2'b00, "async_rst_sel");
    chk(o_led, 4'b0001, "async_rst_led");
    chk(o_tick, 1'b0, "async_rst_tick");
    chk(o_busy, 1'b0, "async_rst_busy");
    cycles(2);
    chk(sb.size(), 0, "sb_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
